// File: rtl/if_fetch_buffer_if.sv
// if_fetch_buffer_if: instruction-memory request/response bus plus the
// decode-side valid/ready handshake of the fetch stage.
//   imem_req/imem_addr   fetch request and its address (fetch -> memory)
//   imem_gnt             memory accepts the request this cycle
//   imem_rvalid/rdata    in-order read response
//   id_valid/id_ready    queue-head handshake toward decode
//   id_instr/id_pc       queue-head payload
// master = fetch stage side, slave = memory/decode environment side.
interface if_fetch_buffer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch stage between the PC register and the
// IF/ID boundary. Issues one outstanding imem request at PC_Addr, advances
// the PC (PC+4 or redirect target) and queues {pc, instr} pairs for decode.
//   clk, rst          clock; synchronous active-low reset
//   PC_Addr           current PC from the PC register
//   new_PC/PC_IFWrite next PC and its load enable
//   redirect/_pc      taken branch/jump: flush everything, restart at _pc
//   bus (master)      imem request/response and decode handshake
module if_fetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        PC_Addr,
  output logic [31:0]        new_PC,
  output logic               PC_IFWrite,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_fetch_buffer_if.master  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // WAIT keeps the pending response, DRAIN throws it away after a redirect.
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] q;
  state_t             state, state_nxt;
  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [31:0]        req_pc;
  logic               req, accept, push, pop, vld;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    // Only one request in flight, and only when a slot is guaranteed free.
    req    = rst & (state == IDLE) & (count < CW'(DEPTH)) & ~redirect;
    accept = req & bus.imem_gnt;
    vld    = rst & (count != '0);
    pop    = vld & bus.id_ready & ~redirect;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT: begin
        if (redirect)             state_nxt = bus.imem_rvalid ? IDLE : DRAIN;
        else if (bus.imem_rvalid) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN:   if (bus.imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    PC_IFWrite    = rst & (redirect | accept);
    new_PC        = redirect ? redirect_pc : PC_Addr + 32'd4;
    bus.imem_req  = req;
    bus.imem_addr = PC_Addr;
    bus.id_valid  = vld;
    bus.id_instr  = rst ? q[head].instr : 32'd0;
    bus.id_pc     = rst ? q[head].pc    : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      req_pc <= '0;
      q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= PC_Addr;
      if (redirect) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) begin
          q[tail] <= {req_pc, bus.imem_rdata};
          tail    <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, new_PC, redirect_pc;
  logic        PC_IFWrite, redirect;

  always #5 clk = ~clk;

  if_fetch_buffer_if bus();

  if_fetch_buffer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC_Addr    (pc),
    .new_PC     (new_PC),
    .PC_IFWrite (PC_IFWrite),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus)
  );

  // External PC register, reset value 0x3000.
  always @(posedge clk)
    if (!rst)            pc <= 32'h3000;
    else if (PC_IFWrite) pc <= new_PC;

  // Memory: fixed latency, data word = {A5A5, addr[15:0]}.
  int          lat;
  int          mem_cnt;
  logic        gnt_block, rv_force, mem_busy;
  logic [31:0] mem_addr;

  assign bus.imem_gnt    = ~gnt_block;
  assign bus.imem_rvalid = (mem_busy && mem_cnt == 0) || rv_force;
  assign bus.imem_rdata  = {16'hA5A5, mem_addr[15:0]};

  always @(posedge clk)
    if (!rst) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (bus.imem_req && bus.imem_gnt) begin
      mem_busy <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= bus.imem_addr;
    end else if (mem_busy) begin
      if (mem_cnt == 0) mem_busy <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle and let combinational outputs settle.
  task automatic nc;
    @(negedge clk);
    #1;
  endtask

  // Two reset edges; returns settled in cycle 0 after release.
  task automatic do_reset;
    rst = 1'b0; redirect = 1'b0; rv_force = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.id_ready = 1'b1; gnt_block = 1'b0; rv_force = 1'b0; lat = 1;

    // Reset state
    nc();
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_wr",    32'(PC_IFWrite),   32'd0);
    chk("rst_vld",   32'(bus.id_valid), 32'd0);
    chk("rst_pc",    bus.id_pc,         32'd0);
    chk("rst_instr", bus.id_instr,      32'd0);

    // Sequential fetch, zero-wait memory
    do_reset();
    chk("seq0_req",   32'(bus.imem_req), 32'd1);
    chk("seq0_addr",  bus.imem_addr,     32'h3000);
    chk("seq0_wr",    32'(PC_IFWrite),   32'd1);
    chk("seq0_newpc", new_PC,            32'h3004);
    chk("seq0_vld",   32'(bus.id_valid), 32'd0);
    nc();
    chk("seq1_req",   32'(bus.imem_req), 32'd0);
    chk("seq1_vld",   32'(bus.id_valid), 32'd0);
    nc();
    chk("seq2_vld",   32'(bus.id_valid), 32'd1);
    chk("seq2_pc",    bus.id_pc,         32'h3000);
    chk("seq2_instr", bus.id_instr,      32'hA5A53000);
    chk("seq2_addr",  bus.imem_addr,     32'h3004);
    nc();
    chk("seq3_vld",   32'(bus.id_valid), 32'd0);
    nc();
    chk("seq4_pc",    bus.id_pc,         32'h3004);
    chk("seq4_instr", bus.id_instr,      32'hA5A53004);
    chk("seq4_addr",  bus.imem_addr,     32'h3008);
    chk("seq4_newpc", new_PC,            32'h300C);
    nc(); nc();
    chk("seq6_vld",   32'(bus.id_valid), 32'd1);
    chk("seq6_pc",    bus.id_pc,         32'h3008);
    chk("seq6_instr", bus.id_instr,      32'hA5A53008);

    // Decode stall: fill DEPTH entries then hold
    bus.id_ready = 1'b0;
    do_reset();
    nc(); nc(); nc(); nc();
    for (int i = 4; i < 7; i++) begin
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      chk("stall_wr",  32'(PC_IFWrite),   32'd0);
      chk("stall_pcr", pc,                32'h3008);
      chk("stall_hd",  bus.id_pc,         32'h3000);
      nc();
    end
    bus.id_ready = 1'b1;
    #1;
    chk("res7_req",   32'(bus.imem_req), 32'd0);
    chk("res7_pc",    bus.id_pc,         32'h3000);
    nc();
    chk("res8_req",   32'(bus.imem_req), 32'd1);
    chk("res8_addr",  bus.imem_addr,     32'h3008);
    chk("res8_pc",    bus.id_pc,         32'h3004);
    chk("res8_instr", bus.id_instr,      32'hA5A53004);
    nc();
    chk("res9_vld",   32'(bus.id_valid), 32'd0);
    nc();
    chk("res10_pc",   bus.id_pc,         32'h3008);
    chk("res10_ins",  bus.id_instr,      32'hA5A53008);

    // Redirect during WAIT, 3-cycle memory
    lat = 3;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h3400;
    #1;
    chk("rdw1_wr",    32'(PC_IFWrite),   32'd1);
    chk("rdw1_newpc", new_PC,            32'h3400);
    chk("rdw1_req",   32'(bus.imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("rdw2_req",   32'(bus.imem_req), 32'd0);
    nc();
    chk("rdw3_req",   32'(bus.imem_req), 32'd0);
    chk("rdw3_vld",   32'(bus.id_valid), 32'd0);
    nc();
    chk("rdw4_req",   32'(bus.imem_req), 32'd1);
    chk("rdw4_addr",  bus.imem_addr,     32'h3400);
    chk("rdw4_vld",   32'(bus.id_valid), 32'd0);
    nc(); nc(); nc();
    chk("rdw7_vld",   32'(bus.id_valid), 32'd0);
    nc();
    chk("rdw8_vld",   32'(bus.id_valid), 32'd1);
    chk("rdw8_pc",    bus.id_pc,         32'h3400);
    chk("rdw8_instr", bus.id_instr,      32'hA5A53400);

    // Redirect together with rvalid and pop
    lat = 1; bus.id_ready = 1'b0;
    do_reset();
    nc(); nc();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h3800; bus.id_ready = 1'b1;
    #1;
    chk("rdp3_wr",    32'(PC_IFWrite),   32'd1);
    chk("rdp3_newpc", new_PC,            32'h3800);
    chk("rdp3_req",   32'(bus.imem_req), 32'd0);
    chk("rdp3_vld",   32'(bus.id_valid), 32'd1);
    chk("rdp3_hd",    bus.id_pc,         32'h3000);
    @(negedge clk);
    redirect = 1'b0; bus.id_ready = 1'b0;
    #1;
    chk("rdp4_vld",   32'(bus.id_valid), 32'd0);
    chk("rdp4_req",   32'(bus.imem_req), 32'd1);
    chk("rdp4_addr",  bus.imem_addr,     32'h3800);
    nc(); nc();
    chk("rdp6_pc",    bus.id_pc,         32'h3800);
    chk("rdp6_instr", bus.id_instr,      32'hA5A53800);

    // Grant back-pressure
    gnt_block = 1'b1; bus.id_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nc();
      chk("gbp_req",  32'(bus.imem_req), 32'd1);
      chk("gbp_addr", bus.imem_addr,     32'h3000);
      chk("gbp_wr",   32'(PC_IFWrite),   32'd0);
    end
    @(negedge clk);
    gnt_block = 1'b0;
    #1;
    chk("gbp4_wr",    32'(PC_IFWrite),   32'd1);
    chk("gbp4_newpc", new_PC,            32'h3004);
    nc();
    chk("gbp5_req",   32'(bus.imem_req), 32'd0);
    nc();
    chk("gbp6_vld",   32'(bus.id_valid), 32'd1);
    chk("gbp6_pc",    bus.id_pc,         32'h3000);

    // Reset while WAIT with one entry queued
    lat = 3; bus.id_ready = 1'b0;
    do_reset();
    nc(); nc(); nc(); nc();
    chk("rw4_vld",    32'(bus.id_valid), 32'd1);
    chk("rw4_addr",   bus.imem_addr,     32'h3004);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw5_req",    32'(bus.imem_req), 32'd0);
    chk("rw5_wr",     32'(PC_IFWrite),   32'd0);
    chk("rw5_vld",    32'(bus.id_valid), 32'd0);
    chk("rw5_pc",     bus.id_pc,         32'd0);
    chk("rw5_instr",  bus.id_instr,      32'd0);
    @(negedge clk);
    rst = 1'b1; gnt_block = 1'b1; rv_force = 1'b1;
    #1;
    chk("rw6_vld",    32'(bus.id_valid), 32'd0);
    chk("rw6_req",    32'(bus.imem_req), 32'd1);
    chk("rw6_addr",   bus.imem_addr,     32'h3000);
    @(negedge clk);
    rv_force = 1'b0;
    #1;
    chk("rw7_vld",    32'(bus.id_valid), 32'd0);
    chk("rw7_req",    32'(bus.imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
